// File: rtl/branch_squash_ctrl.sv
// Decode->execute branch hazard stage: gates branch writes and squashes SQUASH_CYCLES wrong-path slots.
// Latency: 1 cycle, all outputs registered, no input-to-output combinational path.
// Backpressure: Stall_In freezes every register; squash slots are counted on advancing cycles only.
module branch_squash_ctrl #(
    parameter int INST_W        = 17,
    parameter int BS_W          = 2,
    parameter int SQUASH_CYCLES = 1,
    parameter int KEEP_BRANCH   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Stall_In,
    input  logic              Valid_In,
    input  logic [BS_W-1:0]   BS_In,
    input  logic              RW_In,
    input  logic              MW_In,
    input  logic              PS_In,
    input  logic [INST_W-1:0] Inst_In,
    output logic              Valid_O,
    output logic              RW_O,
    output logic              MW_O,
    output logic              PS_O,
    output logic [INST_W-1:0] Inst_O,
    output logic              Flush_O,
    output logic [2:0]        Squash_Cnt_O
);

    typedef struct packed {
        logic              vld;
        logic              rw;
        logic              mw;
        logic              ps;
        logic [INST_W-1:0] inst;
    } slot_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES);

    generate
        if (SQUASH_CYCLES < 0 || SQUASH_CYCLES > 7) begin : g_bad_squash_cycles
            $error("branch_squash_ctrl: SQUASH_CYCLES must be in 0..7");
        end
    endgenerate

    state_t     state;
    logic [2:0] cnt;
    logic       flush_q;
    slot_t      slot_q;
    slot_t      slot_nxt;
    logic       branch_hit;

    // Slot that will be registered on the next advancing edge.
    always_comb begin
        branch_hit = Valid_In && (BS_In != '0) && (state == IDLE);
        slot_nxt   = '0;
        if (state == IDLE) begin
            if (branch_hit) begin
                if (KEEP_BRANCH != 0) begin
                    slot_nxt.vld  = 1'b1;
                    slot_nxt.inst = Inst_In;
                end
            end else if (Valid_In) begin
                slot_nxt.vld  = 1'b1;
                slot_nxt.rw   = RW_In;
                slot_nxt.mw   = MW_In;
                slot_nxt.ps   = PS_In;
                slot_nxt.inst = Inst_In;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            flush_q <= 1'b0;
            slot_q  <= '0;
        end else if (!Stall_In) begin
            slot_q <= slot_nxt;
            case (state)
                IDLE: begin
                    if (branch_hit && SQUASH_CYCLES > 0) begin
                        state   <= SQUASH;
                        cnt     <= SQ_INIT;
                        flush_q <= 1'b1;
                    end
                end
                SQUASH: begin
                    // Every advancing cycle burns one wrong-path slot, bubble or not.
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                    if (cnt <= 3'd1) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 3'd0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign Valid_O      = slot_q.vld;
    assign RW_O         = slot_q.rw;
    assign MW_O         = slot_q.mw;
    assign PS_O         = slot_q.ps;
    assign Inst_O       = slot_q.inst;
    assign Flush_O      = flush_q;
    assign Squash_Cnt_O = cnt;

endmodule

// File: tb/tb_branch_squash_ctrl.sv
// Bench for branch_squash_ctrl: four parameter sets share one stimulus stream and are
// checked every cycle against a slot-index model, plus literal expectations on directed sequences.
module tb_branch_squash_ctrl;

    localparam int NCFG = 4;

    function automatic int sqc(input int i);
        case (i)
            0: return 2;
            1: return 1;
            2: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int kbc(input int i);
        return (i == 1 || i == 3) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rst;
    logic        stall;
    logic        vld_in;
    logic [1:0]  bs_in;
    logic        rw_in, mw_in, ps_in;
    logic [16:0] inst_in;

    logic        valid_o [NCFG];
    logic        rw_o    [NCFG];
    logic        mw_o    [NCFG];
    logic        ps_o    [NCFG];
    logic [16:0] inst_o  [NCFG];
    logic        flush_o [NCFG];
    logic [2:0]  cnt_o   [NCFG];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        branch_squash_ctrl #(
            .INST_W       (17),
            .BS_W         (2),
            .SQUASH_CYCLES(sqc(g)),
            .KEEP_BRANCH  (kbc(g))
        ) u_dut (
            .CLK         (clk),
            .RESET       (rst),
            .Stall_In    (stall),
            .Valid_In    (vld_in),
            .BS_In       (bs_in),
            .RW_In       (rw_in),
            .MW_In       (mw_in),
            .PS_In       (ps_in),
            .Inst_In     (inst_in),
            .Valid_O     (valid_o[g]),
            .RW_O        (rw_o[g]),
            .MW_O        (mw_o[g]),
            .PS_O        (ps_o[g]),
            .Inst_O      (inst_o[g]),
            .Flush_O     (flush_o[g]),
            .Squash_Cnt_O(cnt_o[g])
        );
    end

    // Model: slots are numbered by advancing edges since reset. Slot k is wrong-path when it
    // lies 1..SQ slots after the last accepted branch; the counter is the number of such
    // slots still ahead.
    int          m_k      [NCFG];
    int          m_lastbr [NCFG];
    logic        e_vld    [NCFG];
    logic        e_rw     [NCFG];
    logic        e_mw     [NCFG];
    logic        e_ps     [NCFG];
    logic [16:0] e_inst   [NCFG];
    int          e_cnt    [NCFG];

    initial begin
        for (int i = 0; i < NCFG; i++) begin
            m_k[i] = 0; m_lastbr[i] = -100; e_cnt[i] = 0;
            e_vld[i] = 0; e_rw[i] = 0; e_mw[i] = 0; e_ps[i] = 0; e_inst[i] = '0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NCFG; i++) begin
            if (rst) begin
                m_k[i] = 0; m_lastbr[i] = -100; e_cnt[i] = 0;
                e_vld[i] = 0; e_rw[i] = 0; e_mw[i] = 0; e_ps[i] = 0; e_inst[i] = '0;
            end else if (!stall) begin
                int d;
                d = m_k[i] - m_lastbr[i];
                e_vld[i] = 0; e_rw[i] = 0; e_mw[i] = 0; e_ps[i] = 0; e_inst[i] = '0;
                if (d >= 1 && d <= sqc(i)) begin
                    // wrong-path slot: stays a bubble
                end else if (vld_in && bs_in != 2'b00) begin
                    m_lastbr[i] = m_k[i];
                    if (kbc(i) == 1) begin
                        e_vld[i]  = 1;
                        e_inst[i] = inst_in;
                    end
                end else if (vld_in) begin
                    e_vld[i] = 1; e_rw[i] = rw_in; e_mw[i] = mw_in; e_ps[i] = ps_in;
                    e_inst[i] = inst_in;
                end
                e_cnt[i] = m_lastbr[i] + sqc(i) - m_k[i];
                if (e_cnt[i] < 0) e_cnt[i] = 0;
                m_k[i] = m_k[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NCFG; i++) begin
                logic [31:0] act, exp;
                act = {8'd0, valid_o[i], rw_o[i], mw_o[i], ps_o[i], flush_o[i], cnt_o[i], inst_o[i]};
                exp = {8'd0, e_vld[i], e_rw[i], e_mw[i], e_ps[i], (e_cnt[i] > 0), 3'(e_cnt[i]), e_inst[i]};
                chk($sformatf("model cfg%0d cyc%0d {v,rw,mw,ps,fl,cnt,inst}", i, cyc), act, exp);
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic v, input logic [1:0] bs,
                         input logic rw, input logic mw, input logic ps, input logic [16:0] inst);
        rst = r; stall = s; vld_in = v; bs_in = bs;
        rw_in = rw; mw_in = mw; ps_in = ps; inst_in = inst;
        @(negedge clk);
    endtask

    initial begin
        rst = 0; stall = 0; vld_in = 0; bs_in = 0; rw_in = 0; mw_in = 0; ps_in = 0; inst_in = '0;
        @(negedge clk);

        // Reset with every input high
        drive(1, 1, 1, 2'b11, 1, 1, 1, 17'h1FFFF);
        chk_en = 1;
        chk("reset valid", 32'(valid_o[0]), 0);
        chk("reset inst", 32'(inst_o[0]), 0);
        chk("reset rw/mw/ps", {29'd0, rw_o[0], mw_o[0], ps_o[0]}, 0);
        chk("reset flush", 32'(flush_o[0]), 0);
        chk("reset cnt", 32'(cnt_o[0]), 0);

        // Passthrough
        drive(0, 0, 1, 2'b00, 1, 0, 1, 17'h1ABCD);
        chk("pass inst", 32'(inst_o[0]), 32'h1ABCD);
        chk("pass rw/mw/ps", {29'd0, rw_o[0], mw_o[0], ps_o[0]}, 32'b101);
        chk("pass valid", 32'(valid_o[0]), 1);

        // Branch with two squashed followers (cfg0: KB=0, SQ=2)
        drive(0, 0, 1, 2'b01, 1, 1, 1, 17'h000F0);
        chk("br bubble inst", 32'(inst_o[0]), 0);
        chk("br bubble valid", 32'(valid_o[0]), 0);
        chk("br flush", 32'(flush_o[0]), 1);
        chk("br cnt2", 32'(cnt_o[0]), 2);
        chk("br keep cfg1 inst", 32'(inst_o[1]), 32'h000F0);
        chk("br keep cfg1 rw", 32'(rw_o[1]), 0);
        drive(0, 0, 1, 2'b00, 1, 0, 0, 17'h11111);
        chk("A squashed valid", 32'(valid_o[0]), 0);
        chk("A cnt1", 32'(cnt_o[0]), 1);
        chk("A flush", 32'(flush_o[0]), 1);
        drive(0, 0, 1, 2'b00, 0, 1, 0, 17'h02222);
        chk("B squashed inst", 32'(inst_o[0]), 0);
        chk("B flush low", 32'(flush_o[0]), 0);
        chk("B passes cfg1", 32'(inst_o[1]), 32'h02222);
        drive(0, 0, 1, 2'b00, 1, 1, 0, 17'h03333);
        chk("C passes inst", 32'(inst_o[0]), 32'h03333);
        chk("C passes valid", 32'(valid_o[0]), 1);

        // Stall inside the window (cfg2: SQ=3)
        drive(0, 0, 1, 2'b01, 0, 0, 0, 17'h000AA);
        chk("X cnt3", 32'(cnt_o[2]), 3);
        drive(0, 0, 1, 2'b00, 1, 0, 0, 17'h06666);
        chk("G cnt2", 32'(cnt_o[2]), 2);
        drive(0, 1, 1, 2'b10, 1, 1, 1, 17'h0BEEF);
        chk("stall1 cnt hold", 32'(cnt_o[2]), 2);
        drive(0, 1, 1, 2'b10, 1, 1, 1, 17'h0BEEF);
        chk("stall2 cnt hold", 32'(cnt_o[2]), 2);
        drive(0, 0, 1, 2'b10, 1, 1, 1, 17'h0BEEF);
        chk("wrongpath br cnt1", 32'(cnt_o[2]), 1);
        drive(0, 0, 1, 2'b00, 1, 0, 0, 17'h0CAFE);
        chk("window end flush", 32'(flush_o[2]), 0);
        chk("window end valid", 32'(valid_o[2]), 0);
        drive(0, 0, 1, 2'b00, 0, 1, 1, 17'h04444);
        chk("D passes", 32'(inst_o[2]), 32'h04444);

        // Reset mid-squash (cfg0)
        drive(0, 0, 1, 2'b01, 0, 0, 0, 17'h000BB);
        chk("Y cnt2", 32'(cnt_o[0]), 2);
        drive(1, 0, 0, 2'b00, 0, 0, 0, 17'h00000);
        chk("midrst flush", 32'(flush_o[0]), 0);
        chk("midrst cnt", 32'(cnt_o[0]), 0);
        drive(0, 0, 1, 2'b00, 1, 0, 0, 17'h05555);
        chk("post-rst inst", 32'(inst_o[0]), 32'h05555);
        chk("post-rst valid", 32'(valid_o[0]), 1);

        // Keep-branch mode (cfg1: KB=1, SQ=1) and zero-squash mode (cfg3)
        drive(0, 0, 1, 2'b11, 1, 1, 1, 17'h00123);
        chk("keep inst", 32'(inst_o[1]), 32'h00123);
        chk("keep valid", 32'(valid_o[1]), 1);
        chk("keep rw/mw/ps", {29'd0, rw_o[1], mw_o[1], ps_o[1]}, 0);
        chk("keep cnt1", 32'(cnt_o[1]), 1);
        drive(0, 0, 1, 2'b00, 1, 1, 1, 17'h07777);
        chk("keep next bubble", 32'(valid_o[1]), 0);
        chk("sq0 next passes", 32'(inst_o[3]), 32'h07777);
        chk("sq0 no flush", 32'(flush_o[3]), 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] bs;
            bs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), bs,
                  1'($urandom), 1'($urandom), 1'($urandom), 17'($urandom));
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
